// File: rtl/pb_key_encoder.sv
// -----------------------------------------------------------------------------
// pb_key_encoder
//
// Turns the raw push-button bus into a stream of debounced key codes. The pb
// bus is synchronised into the hz100 domain, priority-encoded (highest index
// wins), and debounced by a small FSM. Each accepted press pushes exactly one
// binary key index into a show-ahead FIFO that the consumer drains with pop.
//
// Parameters
//   N_KEYS      width of the pb bus; code width CW = $clog2(N_KEYS)
//   DEBOUNCE    identical synced samples needed to accept a press or a
//               release (2..15)
//   FIFO_DEPTH  code FIFO entries, power of two
//
// Ports
//   hz100     in   1       system clock, rising edge
//   reset     in   1       asynchronous, active-low; 0 clears all state
//   pb        in   N_KEYS  raw buttons, active-high, asynchronous to hz100
//   pop       in   1       consumer takes the head code this cycle
//   code      out  CW      head-of-FIFO key index (show-ahead), 0 when empty
//   valid     out  1       FIFO non-empty
//   count     out  NW      FIFO occupancy, 0..FIFO_DEPTH
//   held      out  1       a press has been accepted and not yet released
//   overflow  out  1       sticky: a push was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module pb_key_encoder #(
    parameter  int N_KEYS     = 21,
    parameter  int DEBOUNCE   = 3,
    parameter  int FIFO_DEPTH = 4,
    localparam int CW         = $clog2(N_KEYS),
    localparam int NW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              hz100,
    input  logic              reset,
    input  logic [N_KEYS-1:0] pb,
    input  logic              pop,
    output logic [CW-1:0]     code,
    output logic              valid,
    output logic [NW-1:0]     count,
    output logic              held,
    output logic              overflow
);

    localparam int            AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [3:0]    DB_LAST  = 4'(DEBOUNCE - 1);
    localparam logic [NW-1:0] DEPTH_N  = NW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_HELD     = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Two-flop synchroniser. Everything downstream looks only at pb_s_q.
    // -------------------------------------------------------------------------
    logic [N_KEYS-1:0] sync1_q, sync1_d;
    logic [N_KEYS-1:0] pb_s_q,  pb_s_d;

    always_comb begin
        sync1_d = pb;
        pb_s_d  = sync1_q;
    end

    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            pb_s_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            pb_s_q  <= pb_s_d;
        end
    end

    // -------------------------------------------------------------------------
    // Priority encoder: scanning upward lets the highest set bit overwrite
    // lower ones. enc is meaningless when any is low.
    // -------------------------------------------------------------------------
    logic          any;
    logic [CW-1:0] enc;

    always_comb begin
        any = |pb_s_q;
        enc = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (pb_s_q[i]) begin
                enc = CW'(i);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Debounce FSM. cnt counts identical samples already seen in DEBOUNCE or
    // RELEASE; the DEBOUNCE-th identical sample completes the state.
    // -------------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [CW-1:0] cand_q,  cand_d;
    logic [3:0]    cnt_q,   cnt_d;
    logic          held_q,  held_d;
    logic          push;

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        push    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (any) begin
                    state_d = S_DEBOUNCE;
                    cand_d  = enc;
                    cnt_d   = 4'd1;
                end
            end
            S_DEBOUNCE: begin
                // A release or a change of winning key restarts the press.
                if (!any || (enc != cand_q)) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == DB_LAST) begin
                    push    = 1'b1;
                    state_d = S_HELD;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_HELD: begin
                // Key changes while something is still down are ignored, and
                // there is no auto-repeat: only a full release re-arms.
                if (!any) begin
                    state_d = S_RELEASE;
                    cnt_d   = 4'd1;
                end
            end
            S_RELEASE: begin
                if (any) begin
                    // Release bounce: the key is still considered held.
                    state_d = S_HELD;
                    cnt_d   = 4'd0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        // held is registered from the next state so it lines up with the FSM.
        held_d = (state_d == S_HELD) || (state_d == S_RELEASE);
    end

    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            held_q  <= held_d;
        end
    end

    // -------------------------------------------------------------------------
    // Show-ahead code FIFO. A pop on a full FIFO frees the slot the concurrent
    // push needs, so push+pop while full is accepted with no overflow.
    // -------------------------------------------------------------------------
    logic [CW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q,    wr_d;
    logic [AW-1:0] rd_q,    rd_d;
    logic [NW-1:0] count_q, count_d;
    logic          ovf_q,   ovf_d;
    logic          full;
    logic          do_pop;
    logic          do_push;

    always_comb begin
        full    = (count_q == DEPTH_N);
        do_pop  = pop && (count_q != '0);
        do_push = push && (!full || do_pop);

        // Pointers rely on the power-of-two depth to wrap naturally.
        wr_d = do_push ? (wr_q + AW'(1)) : wr_q;
        rd_d = do_pop  ? (rd_q + AW'(1)) : rd_q;

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + NW'(1);
            2'b01:   count_d = count_q - NW'(1);
            default: count_d = count_q;
        endcase

        ovf_d = ovf_q || (push && full && !do_pop);
    end

    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage carries data only; emptiness is tracked by count_q, so the
    // array needs no reset.
    always_ff @(posedge hz100) begin
        if (do_push) begin
            mem_q[wr_q] <= cand_q;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        valid    = (count_q != '0);
        code     = valid ? mem_q[rd_q] : '0;
        count    = count_q;
        held     = held_q;
        overflow = ovf_q;
    end

endmodule

// File: tb/tb_pb_key_encoder.sv
// -----------------------------------------------------------------------------
// tb_pb_key_encoder
//
// Directed bench for pb_key_encoder at default parameters (21 keys,
// DEBOUNCE=3, FIFO_DEPTH=4). Inputs change 1 time unit after a rising edge;
// outputs are sampled at the same point, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_pb_key_encoder;

    localparam int N  = 21;
    localparam int CW = 5;
    localparam int NW = 3;

    logic          hz100;
    logic          reset;
    logic [N-1:0]  pb;
    logic          pop;
    logic [CW-1:0] code;
    logic          valid;
    logic [NW-1:0] count;
    logic          held;
    logic          overflow;

    int n_checks = 0;
    int n_errors = 0;

    pb_key_encoder #(
        .N_KEYS     (21),
        .DEBOUNCE   (3),
        .FIFO_DEPTH (4)
    ) dut (
        .hz100    (hz100),
        .reset    (reset),
        .pb       (pb),
        .pop      (pop),
        .code     (code),
        .valid    (valid),
        .count    (count),
        .held     (held),
        .overflow (overflow)
    );

    initial hz100 = 1'b0;
    always #5 hz100 = ~hz100;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge hz100);
        #1;
    endtask

    function automatic logic [N-1:0] key(input int k);
        logic [N-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    // Hold a key long enough to be accepted, then release long enough for the
    // FSM to return to IDLE.
    task automatic press_release(input int k);
        pb = key(k);
        repeat (6) tick();
        pb = '0;
        repeat (8) tick();
    endtask

    int exp4[4];
    int exp5[4];

    initial begin
        reset = 1'b0;
        pb    = '0;
        pop   = 1'b0;
        exp4  = '{1, 9, 17, 20};
        exp5  = '{6, 10, 14, 18};

        // Reset state
        repeat (3) tick();
        check("rst_code",     code,     0);
        check("rst_valid",    valid,    0);
        check("rst_count",    count,    0);
        check("rst_held",     held,     0);
        check("rst_overflow", overflow, 0);
        reset = 1'b1;
        tick();

        // 1: single press of key 5, latency to edge 4, then pop
        pb = key(5);
        repeat (4) tick();
        check("t1_valid_before_e4", valid, 0);
        tick();
        check("t1_valid", valid, 1);
        check("t1_code",  code,  5);
        check("t1_count", count, 1);
        check("t1_held",  held,  1);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check("t1_pop_valid", valid, 0);
        check("t1_pop_code",  code,  0);
        check("t1_pop_count", count, 0);
        pb = '0;
        repeat (8) tick();
        check("t1_released", held, 0);

        // 2: bouncing key 7 never pushes
        for (int i = 0; i < 6; i++) begin
            pb = (i % 2 == 0) ? key(7) : '0;
            tick();
        end
        pb = '0;
        repeat (6) tick();
        check("t2_count", count, 0);
        check("t2_valid", valid, 0);
        check("t2_held",  held,  0);

        // 3: two keys together, highest wins; partial release ignored
        pb = key(3) | key(12);
        repeat (6) tick();
        check("t3_count", count, 1);
        check("t3_code",  code,  12);
        check("t3_held",  held,  1);
        pb = key(3);
        repeat (8) tick();
        check("t3_partial_count", count, 1);
        check("t3_partial_held",  held,  1);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        pb = '0;
        repeat (8) tick();
        check("t3_end_count", count, 0);
        check("t3_end_held",  held,  0);

        // 4: five presses without pops, fifth overflows
        for (int i = 0; i < 4; i++) press_release(exp4[i]);
        check("t4_full_count",   count,    4);
        check("t4_no_overflow",  overflow, 0);
        press_release(4);
        check("t4_ovf_count",    count,    4);
        check("t4_overflow",     overflow, 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t4_pop%0d_code", i), code, exp4[i]);
            pop = 1'b1;
            tick();
            pop = 1'b0;
        end
        check("t4_empty_valid",  valid,    0);
        check("t4_ovf_sticky",   overflow, 1);

        // Reset clears sticky overflow
        reset = 1'b0;
        #1;
        check("rst2_overflow", overflow, 0);
        check("rst2_count",    count,    0);
        tick();
        reset = 1'b1;
        tick();

        // 5: push and pop on the same edge while full
        press_release(2);
        press_release(6);
        press_release(10);
        press_release(14);
        check("t5_full_count", count, 4);
        pb = key(18);
        repeat (4) tick();
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check("t5_count",    count,    4);
        check("t5_overflow", overflow, 0);
        pb = '0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t5_pop%0d_code", i), code, exp5[i]);
            pop = 1'b1;
            tick();
            pop = 1'b0;
        end
        check("t5_empty_count", count, 0);
        repeat (8) tick();

        // 6: reset mid-DEBOUNCE, then mid-HELD, key 2 held throughout
        pb = key(2);
        repeat (3) tick();
        reset = 1'b0;
        #1;
        check("t6a_rst_code",  code,  0);
        check("t6a_rst_valid", valid, 0);
        check("t6a_rst_count", count, 0);
        check("t6a_rst_held",  held,  0);
        tick();
        tick();
        check("t6a_rst_hold_count", count, 0);
        reset = 1'b1;
        repeat (4) tick();
        check("t6a_before_push", count, 0);
        tick();
        check("t6a_count", count, 1);
        check("t6a_code",  code,  2);
        repeat (8) tick();
        check("t6a_once",  count, 1);
        check("t6a_held",  held,  1);

        reset = 1'b0;
        #1;
        check("t6b_rst_code",  code,  0);
        check("t6b_rst_valid", valid, 0);
        check("t6b_rst_count", count, 0);
        check("t6b_rst_held",  held,  0);
        tick();
        reset = 1'b1;
        repeat (4) tick();
        check("t6b_before_push", count, 0);
        tick();
        check("t6b_count", count, 1);
        check("t6b_code",  code,  2);
        repeat (8) tick();
        check("t6b_once",  count, 1);
        pb = '0;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
